// File: rtl/mem_req_tracker.sv
// Outstanding-request tracker for the sram-like data bus: an in-order FIFO of {wr, tag, killed}
// that pairs each data_data_ok with the oldest accepted request and hides flushed responses.
module mem_req_tracker #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned RSP_REG = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [1:0]                 req_size,
    input  logic [DATA_W/8-1:0]        req_wstrb,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic                       flush,
    output logic                       data_req,
    output logic                       data_wr,
    output logic [1:0]                 data_size,
    output logic [DATA_W/8-1:0]        data_wstrb,
    output logic [ADDR_W-1:0]          data_addr,
    output logic [DATA_W-1:0]          data_wdata,
    input  logic                       data_addr_ok,
    input  logic                       data_data_ok,
    input  logic [DATA_W-1:0]          data_rdata,
    output logic                       rsp_valid,
    output logic                       rsp_wr,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       full,
    output logic                       proto_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] wr_q, killed_q, killed_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic             proto_err_q;
    logic             pop, head_live;

    assign full        = (cnt_q == CW'(DEPTH));
    assign data_req    = req_valid & ~full;
    assign req_ready   = data_req & data_addr_ok;
    assign data_wr     = req_wr;
    assign data_size   = req_size;
    assign data_wstrb  = req_wstrb;
    assign data_addr   = req_addr;
    assign data_wdata  = req_wdata;
    assign outstanding = cnt_q;
    assign proto_err   = proto_err_q;

    // data_data_ok while empty is a protocol error and must not disturb the FIFO.
    assign pop       = data_data_ok & (cnt_q != '0);
    assign head_live = pop & ~killed_q[rd_ptr_q] & ~flush;

    always_comb begin
        cnt_d = cnt_q;
        if (req_ready && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!req_ready && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Killing every slot on flush is safe: free slots get killed=0 again when written,
    // and a slot written in the flush cycle must come out killed anyway.
    always_comb begin
        killed_d = killed_q;
        if (req_ready) begin
            killed_d[wr_ptr_q] = 1'b0;
        end
        if (flush) begin
            killed_d = '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wr_q        <= '0;
            killed_q    <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (req_ready) begin
                wr_q[wr_ptr_q]  <= req_wr;
                tag_q[wr_ptr_q] <= req_tag;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (data_data_ok && cnt_q == '0) begin
                proto_err_q <= 1'b1;
            end
            killed_q <= killed_d;
            cnt_q    <= cnt_d;
        end
    end

    if (RSP_REG != 0) begin : g_rsp_reg
        logic              rsp_valid_q, rsp_wr_q;
        logic [TAG_W-1:0]  rsp_tag_q;
        logic [DATA_W-1:0] rsp_rdata_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rsp_valid_q <= 1'b0;
                rsp_wr_q    <= 1'b0;
                rsp_tag_q   <= '0;
                rsp_rdata_q <= '0;
            end else begin
                rsp_valid_q <= head_live;
                rsp_wr_q    <= head_live & wr_q[rd_ptr_q];
                rsp_tag_q   <= head_live ? tag_q[rd_ptr_q] : '0;
                rsp_rdata_q <= head_live ? data_rdata : '0;
            end
        end

        // A flush arriving as the registered response is presented still cancels it.
        always_comb begin
            rsp_valid = rsp_valid_q & ~flush;
            rsp_wr    = rsp_wr_q;
            rsp_tag   = rsp_tag_q;
            rsp_rdata = rsp_rdata_q;
        end
    end else begin : g_rsp_comb
        always_comb begin
            rsp_valid = head_live;
            rsp_wr    = head_live & wr_q[rd_ptr_q];
            rsp_tag   = head_live ? tag_q[rd_ptr_q] : '0;
            rsp_rdata = head_live ? data_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_req_tracker.sv
// Scoreboard bench: one combinational-response and one registered-response tracker share stimulus;
// expected responses are queued per instance with the cycle they are due and checked by a monitor.
module tb_mem_req_tracker;

    logic        clk, reset;
    logic        req_valid, req_wr, flush, data_addr_ok, data_data_ok;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr, req_wdata, data_rdata;
    logic [4:0]  req_tag;

    logic        d0_req_ready, d0_data_req, d0_data_wr, d0_rsp_valid, d0_rsp_wr, d0_full, d0_perr;
    logic [1:0]  d0_data_size;
    logic [3:0]  d0_data_wstrb;
    logic [31:0] d0_data_addr, d0_data_wdata, d0_rsp_rdata;
    logic [4:0]  d0_rsp_tag;
    logic [2:0]  d0_out;

    logic        d1_req_ready, d1_data_req, d1_data_wr, d1_rsp_valid, d1_rsp_wr, d1_full, d1_perr;
    logic [1:0]  d1_data_size;
    logic [3:0]  d1_data_wstrb;
    logic [31:0] d1_data_addr, d1_data_wdata, d1_rsp_rdata;
    logic [4:0]  d1_rsp_tag;
    logic [2:0]  d1_out;

    typedef struct {
        int          due;
        logic        wr;
        logic [4:0]  tag;
        logic [31:0] rdata;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    int   cyc_n = 0;
    int   n_pass = 0;
    int   n_total = 0;

    mem_req_tracker #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .TAG_W(5), .RSP_REG(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d0_req_ready),
        .req_wr(req_wr), .req_size(req_size), .req_wstrb(req_wstrb), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag), .flush(flush), .data_req(d0_data_req),
        .data_wr(d0_data_wr), .data_size(d0_data_size), .data_wstrb(d0_data_wstrb),
        .data_addr(d0_data_addr), .data_wdata(d0_data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .rsp_valid(d0_rsp_valid),
        .rsp_wr(d0_rsp_wr), .rsp_tag(d0_rsp_tag), .rsp_rdata(d0_rsp_rdata),
        .outstanding(d0_out), .full(d0_full), .proto_err(d0_perr)
    );

    mem_req_tracker #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .TAG_W(5), .RSP_REG(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d1_req_ready),
        .req_wr(req_wr), .req_size(req_size), .req_wstrb(req_wstrb), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag), .flush(flush), .data_req(d1_data_req),
        .data_wr(d1_data_wr), .data_size(d1_data_size), .data_wstrb(d1_data_wstrb),
        .data_addr(d1_data_addr), .data_wdata(d1_data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .rsp_valid(d1_rsp_valid),
        .rsp_wr(d1_rsp_wr), .rsp_tag(d1_rsp_tag), .rsp_rdata(d1_rsp_rdata),
        .outstanding(d1_out), .full(d1_full), .proto_err(d1_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic rec(input string nm, input bit ok, input string act, input string req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, required %s", nm, act, req);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        rec(nm, act === req, $sformatf("0x%0h", act), $sformatf("0x%0h", req));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rv, input logic wr, input logic [4:0] tag, input logic aok,
                          input logic dok, input logic [31:0] rd, input logic fl);
        req_valid    = rv;
        req_wr       = wr;
        req_tag      = tag;
        req_size     = 2'd2;
        req_wstrb    = wr ? 4'hF : 4'h0;
        req_addr     = 32'h1000_0000 | (32'(tag) << 2);
        req_wdata    = 32'hCAFE_0000 | 32'(tag);
        data_addr_ok = aok;
        data_data_ok = dok;
        data_rdata   = rd;
        flush        = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Called in the cycle data_data_ok is driven: comb response due now, registered one next cycle.
    task automatic exp_rsp(input bit to0, input bit to1, input logic wr, input logic [4:0] tag,
                           input logic [31:0] rd);
        exp_t e;
        e.wr = wr;
        e.tag = tag;
        e.rdata = rd;
        if (to0) begin
            e.due = cyc_n;
            q0.push_back(e);
        end
        if (to1) begin
            e.due = cyc_n + 1;
            q1.push_back(e);
        end
    endtask

    task automatic accept(input logic wr, input logic [4:0] tag);
        set_in(1'b1, wr, tag, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
    endtask

    task automatic chk_both(input string nm, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] req);
        chk({nm, "_d0"}, a0, req);
        chk({nm, "_d1"}, a1, req);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (d0_rsp_valid) begin
                if (q0.size() == 0) begin
                    rec("rsp_d0_unexpected", 1'b0, $sformatf("rsp_valid tag=%0d", d0_rsp_tag),
                        "no response");
                end else begin
                    m0 = q0.pop_front();
                    rec("rsp_d0", d0_rsp_wr === m0.wr && d0_rsp_tag === m0.tag &&
                        d0_rsp_rdata === m0.rdata && cyc_n == m0.due,
                        $sformatf("wr=%0b tag=%0d rdata=0x%0h cyc=%0d", d0_rsp_wr, d0_rsp_tag,
                                  d0_rsp_rdata, cyc_n),
                        $sformatf("wr=%0b tag=%0d rdata=0x%0h cyc=%0d", m0.wr, m0.tag, m0.rdata,
                                  m0.due));
                end
            end else if (q0.size() != 0 && q0[0].due < cyc_n) begin
                m0 = q0.pop_front();
                rec("rsp_d0_missing", 1'b0, "rsp_valid=0", $sformatf("tag=%0d", m0.tag));
            end
            if (d1_rsp_valid) begin
                if (q1.size() == 0) begin
                    rec("rsp_d1_unexpected", 1'b0, $sformatf("rsp_valid tag=%0d", d1_rsp_tag),
                        "no response");
                end else begin
                    m1 = q1.pop_front();
                    rec("rsp_d1", d1_rsp_wr === m1.wr && d1_rsp_tag === m1.tag &&
                        d1_rsp_rdata === m1.rdata && cyc_n == m1.due,
                        $sformatf("wr=%0b tag=%0d rdata=0x%0h cyc=%0d", d1_rsp_wr, d1_rsp_tag,
                                  d1_rsp_rdata, cyc_n),
                        $sformatf("wr=%0b tag=%0d rdata=0x%0h cyc=%0d", m1.wr, m1.tag, m1.rdata,
                                  m1.due));
                end
            end else if (q1.size() != 0 && q1[0].due < cyc_n) begin
                m1 = q1.pop_front();
                rec("rsp_d1_missing", 1'b0, "rsp_valid=0", $sformatf("tag=%0d", m1.tag));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        idle();
        #2;
        chk_both("rst_outstanding", 32'(d0_out), 32'(d1_out), 0);
        chk_both("rst_full", 32'(d0_full), 32'(d1_full), 0);
        chk_both("rst_data_req", 32'(d0_data_req), 32'(d1_data_req), 0);
        chk_both("rst_rsp_valid", 32'(d0_rsp_valid), 32'(d1_rsp_valid), 0);
        chk_both("rst_proto_err", 32'(d0_perr), 32'(d1_perr), 0);
        #1 reset = 1'b1;
        step();

        // Fill to DEPTH with loads 1..4, then drain in order.
        set_in(1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("pass_addr", d0_data_addr, 32'h1000_0004);
        chk("pass_wdata", d0_data_wdata, 32'hCAFE_0001);
        chk("req_ready_first", 32'(d0_req_ready), 1);
        step();
        for (int i = 2; i <= 4; i++) accept(1'b0, 5'(i));
        set_in(1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_both("fill_outstanding", 32'(d0_out), 32'(d1_out), 4);
        chk_both("fill_full", 32'(d0_full), 32'(d1_full), 1);
        chk_both("fill_data_req", 32'(d0_data_req), 32'(d1_data_req), 0);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hA + 32'(i), 1'b0);
            exp_rsp(1'b1, 1'b1, 1'b0, 5'(i + 1), 32'hA + 32'(i));
            step();
        end
        idle();
        chk_both("drain_outstanding", 32'(d0_out), 32'(d1_out), 0);
        step();

        // Accept and return in the same cycle.
        accept(1'b0, 5'd6);
        set_in(1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'h66, 1'b0);
        exp_rsp(1'b1, 1'b1, 1'b0, 5'd6, 32'h66);
        step();
        idle();
        chk("same_cycle_outstanding", 32'(d0_out), 1);
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h77, 1'b0);
        exp_rsp(1'b1, 1'b1, 1'b0, 5'd7, 32'h77);
        step();
        idle();
        chk("after_pair_outstanding", 32'(d0_out), 0);
        step();

        // Flush while tag 4 is accepted; all four drain silently.
        for (int i = 1; i <= 3; i++) accept(1'b0, 5'(i));
        set_in(1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        idle();
        chk_both("flush_outstanding", 32'(d0_out), 32'(d1_out), 4);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h50 + 32'(i), 1'b0);
            step();
        end
        idle();
        chk_both("killed_drain_outstanding", 32'(d0_out), 32'(d1_out), 0);
        accept(1'b0, 5'd9);
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h99, 1'b0);
        exp_rsp(1'b1, 1'b1, 1'b0, 5'd9, 32'h99);
        step();
        // A live head popped in a flush cycle is still suppressed.
        accept(1'b0, 5'd10);
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hAA, 1'b1);
        step();
        idle();
        chk("flush_pop_outstanding", 32'(d0_out), 0);
        step();

        // Store response; registered instance presents it one cycle later.
        accept(1'b1, 5'd2);
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1234, 1'b0);
        exp_rsp(1'b1, 1'b1, 1'b1, 5'd2, 32'h1234);
        step();
        idle();
        step();
        // Flush in the registered response cycle cancels only the registered one.
        accept(1'b0, 5'd11);
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hBB, 1'b0);
        exp_rsp(1'b1, 1'b0, 1'b0, 5'd11, 32'hBB);
        step();
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        idle();
        step();

        // data_data_ok while empty.
        chk_both("proto_err_clear", 32'(d0_perr), 32'(d1_perr), 0);
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hEE, 1'b0);
        step();
        idle();
        chk_both("proto_err_set", 32'(d0_perr), 32'(d1_perr), 1);
        chk("empty_ok_outstanding", 32'(d0_out), 0);
        step();
        chk("proto_err_sticky", 32'(d0_perr), 1);

        // Pointer wrap: 10 accept/return pairs.
        for (int i = 0; i < 10; i++) begin
            accept(1'b0, 5'(i));
            chk($sformatf("wrap_outstanding_%0d", i), 32'(d0_out), 1);
            set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
            exp_rsp(1'b1, 1'b1, 1'b0, 5'(i), 32'h100 + 32'(i));
            step();
        end
        idle();
        step();
        step();

        // Asynchronous reset mid-operation.
        accept(1'b0, 5'd20);
        accept(1'b1, 5'd21);
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk_both("mid_rst_outstanding", 32'(d0_out), 32'(d1_out), 0);
        chk_both("mid_rst_full", 32'(d0_full), 32'(d1_full), 0);
        chk_both("mid_rst_data_req", 32'(d0_data_req), 32'(d1_data_req), 0);
        chk_both("mid_rst_rsp_valid", 32'(d0_rsp_valid), 32'(d1_rsp_valid), 0);
        chk_both("mid_rst_rsp_wr", 32'(d0_rsp_wr), 32'(d1_rsp_wr), 0);
        chk_both("mid_rst_rsp_tag", 32'(d0_rsp_tag), 32'(d1_rsp_tag), 0);
        chk_both("mid_rst_rsp_rdata", d0_rsp_rdata, d1_rsp_rdata, 0);
        chk_both("mid_rst_proto_err", 32'(d0_perr), 32'(d1_perr), 0);
        #1 reset = 1'b1;
        step();
        chk("post_rst_outstanding", 32'(d0_out), 0);

        rec("queue_d0_drained", q0.size() == 0, $sformatf("%0d left", q0.size()), "0 left");
        rec("queue_d1_drained", q1.size() == 0, $sformatf("%0d left", q1.size()), "0 left");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
